// File: rtl/btpipe_block_ctrl.sv
// Block-level flow controller for BTPipeIn/BTPipeOut in the okClk domain.
// Offers a block only when it fits in (or is fully held by) the FIFO; counts words/blocks.
module btpipe_block_ctrl #(
  parameter int BLOCK_WORDS = 256,
  parameter int FIFO_DEPTH  = 1024,
  parameter int CNT_W       = 10,
  parameter int LEN_W       = 16,
  parameter int WC_W        = $clog2(BLOCK_WORDS) + 1
) (
  input  logic             okClk,
  input  logic             rstn,
  input  logic             cfg_start,
  input  logic             cfg_abort,
  input  logic             cfg_dir,
  input  logic [LEN_W-1:0] cfg_len_blocks,
  input  logic [CNT_W-1:0] in_fifo_wr_cnt,
  input  logic [CNT_W-1:0] out_fifo_rd_cnt,
  input  logic             pipe_in_valid,
  input  logic             pipe_out_read,
  output logic             pipe_in_ready,
  output logic             pipe_out_ready,
  output logic             busy,
  output logic             done,
  output logic             err_protocol,
  output logic [LEN_W-1:0] blocks_done,
  output logic [WC_W-1:0]  word_cnt,
  output logic [2:0]       dbg_state
);

  // Handshake: a word moves on every cycle the selected strobe is high while the
  // FSM is in READY or BLOCK; ready is only a block-level permission, not per word.

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_ROOM = 3'd1,
    S_READY     = 3'd2,
    S_BLOCK     = 3'd3,
    S_FINISH    = 3'd4
  } state_t;

  localparam logic [CNT_W:0]  DEPTH_C = (CNT_W+1)'(FIFO_DEPTH);
  localparam logic [CNT_W:0]  BLK_C   = (CNT_W+1)'(BLOCK_WORDS);
  localparam logic [WC_W-1:0] BLK_WC  = WC_W'(BLOCK_WORDS);

  state_t             state_q, state_d;
  logic               dir_q, dir_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   blocks_q, blocks_d;
  logic [WC_W-1:0]    word_q, word_d;
  logic               err_q, err_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               in_ready_q, in_ready_d;
  logic               out_ready_q, out_ready_d;

  logic [CNT_W:0]     in_free;
  logic               room_ok;
  logic               sel_strobe;
  logic               opp_strobe;
  logic               stray;
  logic [WC_W-1:0]    word_inc;
  logic [LEN_W-1:0]   blocks_inc;

  assign in_free    = DEPTH_C - {1'b0, in_fifo_wr_cnt};
  assign room_ok    = dir_q ? ({1'b0, out_fifo_rd_cnt} >= BLK_C) : (in_free >= BLK_C);
  assign sel_strobe = dir_q ? pipe_out_read : pipe_in_valid;
  assign opp_strobe = dir_q ? pipe_in_valid : pipe_out_read;
  assign stray      = opp_strobe ||
                      (sel_strobe && !((state_q == S_READY) || (state_q == S_BLOCK)));
  assign word_inc   = word_q + WC_W'(1);
  assign blocks_inc = blocks_q + LEN_W'(1);

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    len_d       = len_q;
    blocks_d    = blocks_q;
    word_d      = word_q;
    err_d       = err_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    in_ready_d  = 1'b0;
    out_ready_d = 1'b0;

    if (stray) err_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cfg_start && !cfg_abort) begin
          dir_d    = cfg_dir;
          len_d    = cfg_len_blocks;
          blocks_d = '0;
          word_d   = '0;
          err_d    = 1'b0;
          busy_d   = 1'b1;
          state_d  = (cfg_len_blocks == '0) ? S_FINISH : S_WAIT_ROOM;
        end
      end
      S_WAIT_ROOM: begin
        if (room_ok) state_d = S_READY;
      end
      S_READY, S_BLOCK: begin
        if (sel_strobe) begin
          if (word_inc == BLK_WC) begin
            blocks_d = blocks_inc;
            word_d   = '0;
            state_d  = (blocks_inc == len_q) ? S_FINISH : S_WAIT_ROOM;
          end else begin
            word_d  = word_inc;
            state_d = S_BLOCK;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    // Abort overrides everything above; counters stay frozen for readback.
    if (cfg_abort && busy_q) begin
      state_d  = S_IDLE;
      busy_d   = 1'b0;
      done_d   = 1'b0;
      word_d   = word_q;
      blocks_d = blocks_q;
    end

    in_ready_d  = (state_d == S_READY) && !dir_d;
    out_ready_d = (state_d == S_READY) && dir_d;
  end

  always_ff @(posedge okClk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= S_IDLE;
      dir_q       <= 1'b0;
      len_q       <= '0;
      blocks_q    <= '0;
      word_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      in_ready_q  <= 1'b0;
      out_ready_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      len_q       <= len_d;
      blocks_q    <= blocks_d;
      word_q      <= word_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      in_ready_q  <= in_ready_d;
      out_ready_q <= out_ready_d;
    end
  end

  assign pipe_in_ready  = in_ready_q;
  assign pipe_out_ready = out_ready_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err_protocol   = err_q;
  assign blocks_done    = blocks_q;
  assign word_cnt       = word_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_btpipe_block_ctrl.sv
// Directed bench for btpipe_block_ctrl: a vector table for short sequences plus
// hand-written multi-block, room-threshold, abort and reset sequences.
module tb_btpipe_block_ctrl;

  localparam int LEN_W = 16;
  localparam int CNT_W = 10;
  localparam int WC_W  = 9;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WAIT = 3'd1;
  localparam logic [2:0] ST_RDY  = 3'd2;
  localparam logic [2:0] ST_BLK  = 3'd3;
  localparam logic [2:0] ST_FIN  = 3'd4;

  logic             okClk;
  logic             rstn;
  logic             cfg_start;
  logic             cfg_abort;
  logic             cfg_dir;
  logic [LEN_W-1:0] cfg_len_blocks;
  logic [CNT_W-1:0] in_fifo_wr_cnt;
  logic [CNT_W-1:0] out_fifo_rd_cnt;
  logic             pipe_in_valid;
  logic             pipe_out_read;
  logic             pipe_in_ready;
  logic             pipe_out_ready;
  logic             busy;
  logic             done;
  logic             err_protocol;
  logic [LEN_W-1:0] blocks_done;
  logic [WC_W-1:0]  word_cnt;
  logic [2:0]       dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [LEN_W-1:0] exp_q[$];

  btpipe_block_ctrl #(
    .BLOCK_WORDS(256), .FIFO_DEPTH(1024), .CNT_W(CNT_W), .LEN_W(LEN_W)
  ) dut (
    .okClk(okClk), .rstn(rstn),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_dir(cfg_dir),
    .cfg_len_blocks(cfg_len_blocks),
    .in_fifo_wr_cnt(in_fifo_wr_cnt), .out_fifo_rd_cnt(out_fifo_rd_cnt),
    .pipe_in_valid(pipe_in_valid), .pipe_out_read(pipe_out_read),
    .pipe_in_ready(pipe_in_ready), .pipe_out_ready(pipe_out_ready),
    .busy(busy), .done(done), .err_protocol(err_protocol),
    .blocks_done(blocks_done), .word_cnt(word_cnt), .dbg_state(dbg_state)
  );

  // Clock / reset
  initial begin
    okClk = 1'b0;
    forever #5 okClk = ~okClk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic             st, ab, dir;
    logic [LEN_W-1:0] len;
    logic             iv, orr;
    logic             e_ir, e_or, e_busy, e_done, e_err;
    logic [LEN_W-1:0] e_blk;
    logic [WC_W-1:0]  e_word;
    logic [2:0]       e_st;
  } vec_t;

  function automatic vec_t mk(input logic st, ab, dir, input logic [LEN_W-1:0] len,
                              input logic iv, orr, e_ir, e_or, e_busy, e_done, e_err,
                              input logic [LEN_W-1:0] e_blk, input logic [WC_W-1:0] e_word,
                              input logic [2:0] e_st);
    vec_t v;
    v.st = st; v.ab = ab; v.dir = dir; v.len = len; v.iv = iv; v.orr = orr;
    v.e_ir = e_ir; v.e_or = e_or; v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
    v.e_blk = e_blk; v.e_word = e_word; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ir, orr, bz, dn, er,
                          input logic [LEN_W-1:0] blk, input logic [WC_W-1:0] wd,
                          input logic [2:0] st);
    chk({tag, ".pipe_in_ready"},  32'(pipe_in_ready),  32'(ir));
    chk({tag, ".pipe_out_ready"}, 32'(pipe_out_ready), 32'(orr));
    chk({tag, ".busy"},           32'(busy),           32'(bz));
    chk({tag, ".done"},           32'(done),           32'(dn));
    chk({tag, ".err_protocol"},   32'(err_protocol),   32'(er));
    chk({tag, ".blocks_done"},    32'(blocks_done),    32'(blk));
    chk({tag, ".word_cnt"},       32'(word_cnt),       32'(wd));
    chk({tag, ".state"},          32'(dbg_state),      32'(st));
  endtask

  // Driver tasks
  task automatic drive_idle();
    cfg_start = 1'b0; cfg_abort = 1'b0;
    pipe_in_valid = 1'b0; pipe_out_read = 1'b0;
  endtask

  task automatic tick();
    @(posedge okClk);
    #1;
  endtask

  task automatic start_xfer(input logic d, input logic [LEN_W-1:0] len);
    drive_idle();
    cfg_start = 1'b1; cfg_dir = d; cfg_len_blocks = len;
    tick();
    drive_idle();
  endtask

  // Streams one full 256-word block starting in READY.
  task automatic strobe_block(input logic d, input logic [LEN_W-1:0] exp_blk,
                              input logic [2:0] exp_st, input string tag);
    for (int i = 0; i < 256; i++) begin
      drive_idle();
      if (d) pipe_out_read = 1'b1; else pipe_in_valid = 1'b1;
      tick();
      chk({tag, ".in_rdy"},  32'(pipe_in_ready),  32'd0);
      chk({tag, ".out_rdy"}, 32'(pipe_out_ready), 32'd0);
      if (i < 255) begin
        chk({tag, ".word"},  32'(word_cnt),  32'(i + 1));
        chk({tag, ".state"}, 32'(dbg_state), 32'(ST_BLK));
      end else begin
        chk({tag, ".word_end"},   32'(word_cnt),    32'd0);
        chk({tag, ".blocks_end"}, 32'(blocks_done), 32'(exp_blk));
        chk({tag, ".state_end"},  32'(dbg_state),   32'(exp_st));
      end
    end
    drive_idle();
  endtask

  // Scoreboard: every done pulse must match a queued expected block count.
  initial begin
    forever begin
      @(posedge okClk);
      #1;
      if (done === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done actual=1 required=0 blocks_done=%0d", blocks_done);
        end else begin
          chk("done_blocks", 32'(blocks_done), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  vec_t vecs[15];

  initial begin
    rstn = 1'b0;
    cfg_start = 1'b1; cfg_abort = 1'b0; cfg_dir = 1'b1; cfg_len_blocks = 16'd3;
    in_fifo_wr_cnt = 10'd0; out_fifo_rd_cnt = 10'd512;
    pipe_in_valid = 1'b1; pipe_out_read = 1'b1;
    repeat (3) @(posedge okClk);
    #1;
    chk_outs("reset", 0, 0, 0, 0, 0, 16'd0, 9'd0, ST_IDLE);
    @(negedge okClk);
    drive_idle();
    cfg_dir = 1'b0; cfg_len_blocks = '0; out_fifo_rd_cnt = 10'd0;
    rstn = 1'b1;

    //            st ab dir len    iv or  ir or bz dn er blk wd  state
    vecs[0]  = mk(0, 0, 0, 16'd0, 0, 0,  0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    vecs[1]  = mk(0, 0, 0, 16'd0, 1, 0,  0, 0, 0, 0, 1, 0, 0, ST_IDLE);
    vecs[2]  = mk(0, 0, 0, 16'd0, 0, 1,  0, 0, 0, 0, 1, 0, 0, ST_IDLE);
    vecs[3]  = mk(0, 0, 0, 16'd0, 0, 0,  0, 0, 0, 0, 1, 0, 0, ST_IDLE);
    vecs[4]  = mk(1, 0, 0, 16'd0, 0, 0,  0, 0, 1, 0, 0, 0, 0, ST_FIN);
    vecs[5]  = mk(0, 0, 0, 16'd0, 0, 0,  0, 0, 0, 1, 0, 0, 0, ST_IDLE);
    vecs[6]  = mk(0, 0, 0, 16'd0, 0, 0,  0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    vecs[7]  = mk(1, 1, 0, 16'd2, 0, 0,  0, 0, 0, 0, 0, 0, 0, ST_IDLE);
    vecs[8]  = mk(1, 0, 0, 16'd2, 0, 0,  0, 0, 1, 0, 0, 0, 0, ST_WAIT);
    vecs[9]  = mk(0, 0, 0, 16'd0, 0, 0,  1, 0, 1, 0, 0, 0, 0, ST_RDY);
    vecs[10] = mk(1, 0, 1, 16'd5, 0, 0,  1, 0, 1, 0, 0, 0, 0, ST_RDY);
    vecs[11] = mk(0, 0, 0, 16'd0, 1, 0,  0, 0, 1, 0, 0, 0, 1, ST_BLK);
    vecs[12] = mk(0, 0, 0, 16'd0, 1, 1,  0, 0, 1, 0, 1, 0, 2, ST_BLK);
    vecs[13] = mk(0, 1, 0, 16'd0, 0, 0,  0, 0, 0, 0, 1, 0, 2, ST_IDLE);
    vecs[14] = mk(0, 0, 0, 16'd0, 0, 0,  0, 0, 0, 0, 1, 0, 2, ST_IDLE);

    exp_q.push_back(16'd0);
    for (int i = 0; i < 15; i++) begin
      cfg_start = vecs[i].st; cfg_abort = vecs[i].ab; cfg_dir = vecs[i].dir;
      cfg_len_blocks = vecs[i].len;
      pipe_in_valid = vecs[i].iv; pipe_out_read = vecs[i].orr;
      tick();
      chk_outs($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_or, vecs[i].e_busy,
               vecs[i].e_done, vecs[i].e_err, vecs[i].e_blk, vecs[i].e_word, vecs[i].e_st);
    end
    drive_idle();

    // Two-block pipe-in transfer
    exp_q.push_back(16'd2);
    in_fifo_wr_cnt = 10'd0;
    start_xfer(1'b0, 16'd2);
    chk_outs("t2_start", 0, 0, 1, 0, 0, 16'd0, 9'd0, ST_WAIT);
    tick();
    chk_outs("t2_ready0", 1, 0, 1, 0, 0, 16'd0, 9'd0, ST_RDY);
    strobe_block(1'b0, 16'd1, ST_WAIT, "t2_blk0");
    tick();
    chk_outs("t2_ready1", 1, 0, 1, 0, 0, 16'd1, 9'd0, ST_RDY);
    strobe_block(1'b0, 16'd2, ST_FIN, "t2_blk1");
    tick();
    chk_outs("t2_done", 0, 0, 0, 1, 0, 16'd2, 9'd0, ST_IDLE);
    tick();
    chk_outs("t2_after", 0, 0, 0, 0, 0, 16'd2, 9'd0, ST_IDLE);

    // Pipe-in room threshold
    in_fifo_wr_cnt = 10'd800;
    start_xfer(1'b0, 16'd1);
    for (int i = 0; i < 50; i++) begin
      tick();
      chk("t3_noroom_rdy", 32'(pipe_in_ready), 32'd0);
      chk("t3_noroom_st",  32'(dbg_state),     32'(ST_WAIT));
    end
    in_fifo_wr_cnt = 10'd769;
    tick();
    chk_outs("t3_free255", 0, 0, 1, 0, 0, 16'd0, 9'd0, ST_WAIT);
    in_fifo_wr_cnt = 10'd768;
    tick();
    chk_outs("t3_free256", 1, 0, 1, 0, 0, 16'd0, 9'd0, ST_RDY);
    exp_q.push_back(16'd1);
    strobe_block(1'b0, 16'd1, ST_FIN, "t3_blk");
    tick();
    chk_outs("t3_done", 0, 0, 0, 1, 0, 16'd1, 9'd0, ST_IDLE);

    // Pipe-out, three blocks, data-available threshold
    in_fifo_wr_cnt = 10'd0;
    out_fifo_rd_cnt = 10'd255;
    start_xfer(1'b1, 16'd3);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk_outs("t4_short", 0, 0, 1, 0, 0, 16'd0, 9'd0, ST_WAIT);
    end
    out_fifo_rd_cnt = 10'd256;
    tick();
    chk_outs("t4_ready0", 0, 1, 1, 0, 0, 16'd0, 9'd0, ST_RDY);
    exp_q.push_back(16'd3);
    for (int b = 1; b <= 3; b++) begin
      strobe_block(1'b1, 16'(b), (b == 3) ? ST_FIN : ST_WAIT, $sformatf("t4_blk%0d", b));
      if (b < 3) begin
        tick();
        chk_outs("t4_reready", 0, 1, 1, 0, 0, 16'(b), 9'd0, ST_RDY);
      end
    end
    tick();
    chk_outs("t4_done", 0, 0, 0, 1, 0, 16'd3, 9'd0, ST_IDLE);

    // Opposite-direction stray during a pipe-out block, then abort
    start_xfer(1'b1, 16'd1);
    tick();
    chk_outs("t5_ready", 0, 1, 1, 0, 0, 16'd0, 9'd0, ST_RDY);
    pipe_out_read = 1'b1;
    tick();
    chk_outs("t5_word1", 0, 0, 1, 0, 0, 16'd0, 9'd1, ST_BLK);
    pipe_out_read = 1'b0; pipe_in_valid = 1'b1;
    tick();
    chk_outs("t5_stray", 0, 0, 1, 0, 1, 16'd0, 9'd1, ST_BLK);
    drive_idle();
    cfg_abort = 1'b1;
    tick();
    chk_outs("t5_abort", 0, 0, 0, 0, 1, 16'd0, 9'd1, ST_IDLE);

    // Abort after 100 words of block 0; start clears the sticky flag
    start_xfer(1'b0, 16'd4);
    chk_outs("t6_start", 0, 0, 1, 0, 0, 16'd0, 9'd0, ST_WAIT);
    tick();
    for (int i = 0; i < 100; i++) begin
      pipe_in_valid = 1'b1;
      tick();
    end
    drive_idle();
    chk_outs("t6_100w", 0, 0, 1, 0, 0, 16'd0, 9'd100, ST_BLK);
    cfg_abort = 1'b1;
    tick();
    drive_idle();
    chk_outs("t6_abort", 0, 0, 0, 0, 0, 16'd0, 9'd100, ST_IDLE);
    tick();
    chk_outs("t6_hold", 0, 0, 0, 0, 0, 16'd0, 9'd100, ST_IDLE);

    // Asynchronous reset in the middle of a block
    start_xfer(1'b0, 16'd1);
    tick();
    for (int i = 0; i < 10; i++) begin
      pipe_in_valid = 1'b1;
      tick();
    end
    drive_idle();
    chk("t7_pre_word", 32'(word_cnt), 32'd10);
    #2;
    rstn = 1'b0;
    #1;
    chk_outs("t7_async", 0, 0, 0, 0, 0, 16'd0, 9'd0, ST_IDLE);
    @(negedge okClk);
    rstn = 1'b1;
    tick();
    chk_outs("t7_release", 0, 0, 0, 0, 0, 16'd0, 9'd0, ST_IDLE);

    tick();
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
